quad_step_decoder: RTL and testbench

Quadrature decoder that turns two raw encoder phases (A/B) into single-cycle `inc`/`dec` step pulses, the producer side of the inc/dec interface consumed by the up/down counter. Each phase is synchronised and glitch-filtered, and every legal Gray-code step is decoded into one pulse. Illegal double transitions are flagged and counted instead of being decoded. Sits between the encoder input pins and the position counter.

---
 rtl/quad_step_decoder.sv | 192 +++++++++++++++++++
 tb/tb_quad_step_decoder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/quad_step_decoder.sv
// quad_step_decoder
//   Turns two raw quadrature encoder phases into single-cycle inc/dec step
//   pulses for the position counter. Each phase is synchronised (two flops),
//   then glitch-filtered: the filtered level only follows the synchronised
//   level after FILT_LEN consecutive mismatching cycles. Legal Gray-code steps
//   of the filtered phase {fa, fb} are decoded into one pulse each. A double
//   transition (both bits at once) is flagged in a sticky err and counted in
//   a saturating err_cnt instead of being decoded.
//
// Ports
//   clk      in  : single clock, rising edge
//   rst      in  : synchronous active-high reset
//   qa, qb   in  : raw encoder phases, asynchronous to clk
//   err_clr  in  : one-cycle clear of err/err_cnt (a coincident error wins)
//   inc      out : one-cycle pulse per forward step
//   dec      out : one-cycle pulse per reverse step
//   err      out : sticky illegal-transition flag
//   err_cnt  out : saturating illegal-transition count
//   phase    out : current filtered phase {fa, fb}
module quad_step_decoder #(
  parameter int FILT_LEN = 8,
  parameter int FILT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       qa,
  input  logic       qb,
  input  logic       err_clr,
  output logic       inc,
  output logic       dec,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    SYNC_FILL = 2'b00,
    LOAD      = 2'b01,
    RUN       = 2'b10
  } state_e;

  localparam logic [FILT_W-1:0] CNT_LAST = FILT_W'(FILT_LEN - 1);

  state_e            state_q, state_d;
  logic              fill_q, fill_d;
  logic              a_meta_q, a_meta_d, sa_q, sa_d;
  logic              b_meta_q, b_meta_d, sb_q, sb_d;
  logic              fa_q, fa_d, fb_q, fb_d;
  logic [FILT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [1:0]        prev_q, prev_d;
  logic              inc_q, inc_d, dec_q, dec_d, err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              bad_s;
  logic [FILT_W:0]   filt_a_s, filt_b_s;

  // One filter step: returns {next filtered level, next counter}.
  function automatic logic [FILT_W:0] filt_step(input logic s, input logic f,
                                                input logic [FILT_W-1:0] cnt);
    logic [FILT_W:0] r;
    if (s == f) begin
      r = {f, {FILT_W{1'b0}}};
    end else if (cnt == CNT_LAST) begin
      r = {s, {FILT_W{1'b0}}};
    end else begin
      r = {f, cnt + FILT_W'(1)};
    end
    return r;
  endfunction

  // Next-state logic: synchroniser shift, FSM, filters, decode and error tracking.
  always_comb begin
    a_meta_d  = qa;
    sa_d      = a_meta_q;
    b_meta_d  = qb;
    sb_d      = b_meta_q;
    state_d   = state_q;
    fill_d    = fill_q;
    fa_d      = fa_q;
    fb_d      = fb_q;
    cnt_a_d   = cnt_a_q;
    cnt_b_d   = cnt_b_q;
    prev_d    = prev_q;
    inc_d     = 1'b0;
    dec_d     = 1'b0;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    bad_s     = 1'b0;
    filt_a_s  = filt_step(sa_q, fa_q, cnt_a_q);
    filt_b_s  = filt_step(sb_q, fb_q, cnt_b_q);

    case (state_q)
      SYNC_FILL: begin
        // Two cycles so sa/sb hold real input levels before LOAD copies them.
        if (fill_q) begin
          state_d = LOAD;
          fill_d  = 1'b0;
        end else begin
          fill_d  = 1'b1;
        end
      end
      LOAD: begin
        // Acquire current levels directly; prev tracks them so RUN starts quiet.
        fa_d    = sa_q;
        fb_d    = sb_q;
        prev_d  = {sa_q, sb_q};
        cnt_a_d = {FILT_W{1'b0}};
        cnt_b_d = {FILT_W{1'b0}};
        state_d = RUN;
      end
      RUN: begin
        fa_d    = filt_a_s[FILT_W];
        cnt_a_d = filt_a_s[FILT_W-1:0];
        fb_d    = filt_b_s[FILT_W];
        cnt_b_d = filt_b_s[FILT_W-1:0];
        // prev lags the filtered phase by one edge; the pair decodes the step.
        prev_d  = {fa_q, fb_q};
        case ({prev_q, fa_q, fb_q})
          4'b0010, 4'b1011, 4'b1101, 4'b0100: inc_d = 1'b1;
          4'b0001, 4'b0111, 4'b1110, 4'b1000: dec_d = 1'b1;
          4'b0011, 4'b0110, 4'b1001, 4'b1100: bad_s = 1'b1;
          default: bad_s = 1'b0;
        endcase
      end
      default: begin
        state_d = SYNC_FILL;
        fill_d  = 1'b0;
      end
    endcase

    // A new error beats a coincident clear: the count restarts at 1.
    if (bad_s) begin
      err_d = 1'b1;
      if (err_clr) begin
        err_cnt_d = 8'd1;
      end else if (err_cnt_q == 8'hFF) begin
        err_cnt_d = 8'hFF;
      end else begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end else if (err_clr) begin
      err_d     = 1'b0;
      err_cnt_d = 8'd0;
    end else begin
      err_d     = err_q;
      err_cnt_d = err_cnt_q;
    end
  end

  // State register with synchronous reset; reset drops any in-flight pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SYNC_FILL;
      fill_q    <= 1'b0;
      a_meta_q  <= 1'b0;
      sa_q      <= 1'b0;
      b_meta_q  <= 1'b0;
      sb_q      <= 1'b0;
      fa_q      <= 1'b0;
      fb_q      <= 1'b0;
      cnt_a_q   <= {FILT_W{1'b0}};
      cnt_b_q   <= {FILT_W{1'b0}};
      prev_q    <= 2'b00;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      a_meta_q  <= a_meta_d;
      sa_q      <= sa_d;
      b_meta_q  <= b_meta_d;
      sb_q      <= sb_d;
      fa_q      <= fa_d;
      fb_q      <= fb_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
      prev_q    <= prev_d;
      inc_q     <= inc_d;
      dec_q     <= dec_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign inc     = inc_q;
  assign dec     = dec_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign phase   = {fa_q, fb_q};

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder (FILT_LEN = 8). Inputs change 1 time
// unit after a rising edge; outputs are sampled at the same point, i.e. they
// show the state registered by the edge just passed.
module tb_quad_step_decoder;

  logic       clk = 1'b0;
  logic       rst, qa, qb, err_clr;
  logic       inc, dec, err;
  logic [7:0] err_cnt;
  logic [1:0] phase;

  int checks = 0;
  int errors = 0;

  // Pulse monitor, sampled on the falling edge.
  int   n_inc = 0, n_dec = 0, n_both = 0, n_wide = 0;
  logic inc_prev = 1'b0, dec_prev = 1'b0;
  int   base_inc, base_dec;

  quad_step_decoder #(.FILT_LEN(8), .FILT_W(4)) dut (
    .clk(clk), .rst(rst), .qa(qa), .qb(qb), .err_clr(err_clr),
    .inc(inc), .dec(dec), .err(err), .err_cnt(err_cnt), .phase(phase)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    n_inc    <= n_inc + (inc ? 1 : 0);
    n_dec    <= n_dec + (dec ? 1 : 0);
    n_both   <= n_both + ((inc && dec) ? 1 : 0);
    n_wide   <= n_wide + (((inc && inc_prev) || (dec && dec_prev)) ? 1 : 0);
    inc_prev <= inc;
    dec_prev <= dec;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic snap();
    tick(0);
    #0;
    base_inc = n_inc;
    base_dec = n_dec;
  endtask

  initial begin
    rst = 1'b1; qa = 1'b1; qb = 1'b1; err_clr = 1'b0;
    tick(3);
    check("rst_inc", inc, 1'b0);
    check("rst_dec", dec, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_err_cnt", err_cnt, 8'd0);
    check("rst_phase", phase, 2'b00);

    // Release with inputs at 11: LOAD acquires 11 on the third edge, quietly.
    snap();
    rst = 1'b0;
    tick(2);
    check("pre_load_phase", phase, 2'b00);
    tick(1);
    check("load_phase_11", phase, 2'b11);
    tick(50);
    check("load_no_inc", n_inc - base_inc, 0);
    check("load_no_dec", n_dec - base_dec, 0);
    check("load_no_err", err, 1'b0);

    // Re-acquire at 00 for the step sequences.
    rst = 1'b1; qa = 1'b0; qb = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(3);
    check("reacq_phase_00", phase, 2'b00);

    // Forward 00->10->11->01->00; the first step also checks latency.
    snap();
    qa = 1'b1;
    tick(10);
    check("lat_before", inc, 1'b0);
    tick(1);
    check("lat_rise", inc, 1'b1);
    tick(1);
    check("lat_fall", inc, 1'b0);
    tick(8);
    qb = 1'b1; tick(20);
    qa = 1'b0; tick(20);
    qb = 1'b0; tick(20);
    check("fwd_inc_count", n_inc - base_inc, 4);
    check("fwd_dec_count", n_dec - base_dec, 0);
    check("fwd_phase", phase, 2'b00);

    // Reverse 00->01->11->10->00.
    snap();
    qb = 1'b1; tick(20);
    qa = 1'b1; tick(20);
    qb = 1'b0; tick(20);
    qa = 1'b0; tick(20);
    check("rev_dec_count", n_dec - base_dec, 4);
    check("rev_inc_count", n_inc - base_inc, 0);
    check("rev_phase", phase, 2'b00);
    check("pulse_width", n_wide, 0);
    check("pulse_exclusive", n_both, 0);

    // 7-cycle glitch on qa is absorbed by the filter.
    snap();
    qa = 1'b1; tick(7);
    qa = 1'b0; tick(20);
    check("glitch7_phase", phase, 2'b00);
    check("glitch7_no_inc", n_inc - base_inc, 0);

    // 8-cycle glitch just passes: phase 10 and an inc pulse, later a return dec.
    snap();
    qa = 1'b1; tick(8);
    qa = 1'b0; tick(3);
    check("glitch8_phase", phase, 2'b10);
    check("glitch8_inc", inc, 1'b1);
    tick(30);
    check("glitch8_inc_count", n_inc - base_inc, 1);
    check("glitch8_phase_back", phase, 2'b00);

    // Double transition 00->11 is an error, not a step.
    snap();
    qa = 1'b1; qb = 1'b1; tick(20);
    check("dbl_err", err, 1'b1);
    check("dbl_err_cnt", err_cnt, 8'd1);
    check("dbl_phase", phase, 2'b11);
    for (int i = 1; i < 300; i++) begin
      qa = ~qa; qb = ~qb;
      tick(10);
    end
    tick(5);
    check("sat_err_cnt", err_cnt, 8'd255);
    check("sat_err", err, 1'b1);
    check("dbl_no_inc", n_inc - base_inc, 0);
    check("dbl_no_dec", n_dec - base_dec, 0);
    check("sat_phase", phase, 2'b00);

    // Clear alone.
    err_clr = 1'b1; tick(1);
    err_clr = 1'b0;
    check("clr_err", err, 1'b0);
    check("clr_err_cnt", err_cnt, 8'd0);

    // Clear coincident with a new error: error wins, count restarts at 1.
    qa = 1'b1; qb = 1'b1; tick(20);
    check("pre_coinc_cnt", err_cnt, 8'd1);
    qa = 1'b0; qb = 1'b0; tick(10);
    err_clr = 1'b1; tick(1);
    err_clr = 1'b0;
    check("coinc_err", err, 1'b1);
    check("coinc_err_cnt", err_cnt, 8'd1);
    tick(10);

    // Reset on the edge where an inc would register.
    snap();
    qa = 1'b1; tick(10);
    check("mid_pre_phase", phase, 2'b10);
    rst = 1'b1; tick(1);
    check("mid_inc", inc, 1'b0);
    check("mid_err", err, 1'b0);
    check("mid_err_cnt", err_cnt, 8'd0);
    check("mid_phase", phase, 2'b00);
    rst = 1'b0;
    tick(3);
    check("mid_reacq_phase", phase, 2'b10);
    tick(30);
    check("mid_no_inc", n_inc - base_inc, 0);
    check("mid_no_dec", n_dec - base_dec, 0);
    check("mid_no_err", err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
